// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the BCD counter family.
package bcd_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic is_bcd(input logic [3:0] nib);
    return nib <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: clear/load/increment/decrement with decade wrap; flags 9 and 0.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       sclr,
  input  logic       ld,
  input  logic [3:0] ld_d,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] q,
  output logic       is9,
  output logic       is0
);
  assign is9 = (q == BCD_MAX);
  assign is0 = (q == BCD_MIN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     q <= BCD_MIN;
    else if (sclr) q <= BCD_MIN;
    else if (ld)   q <= ld_d;
    else if (inc)  q <= is9 ? BCD_MIN : q + 4'd1;
    else if (dec)  q <= is0 ? BCD_MAX : q - 4'd1;
  end
endmodule

// File: rtl/bcd_updn_cntr_n.sv
// N-digit synchronous BCD up/down counter with load, sync clear, wrap/saturate.
// Carries/borrows are a combinational prefix chain so every digit steps on one edge.
module bcd_updn_cntr_n
  import bcd_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int SAT  = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sclr,
  input  logic              load,
  input  logic [4*NDIG-1:0] ld_val,
  input  logic              cnt_en,
  input  logic              up_dn,
  output logic [4*NDIG-1:0] count,
  output logic              tc,
  output logic              ovf,
  output logic              ld_err
);
  logic [NDIG-1:0][3:0] ld_d, q;
  logic [NDIG-1:0]      is9, is0, dig_ok, inc, dec;
  logic [NDIG:0]        cy, bw;
  logic                 ld_ok, ld_take, hold_end, step;

  assign ld_d  = ld_val;
  assign count = q;

  assign ld_ok    = &dig_ok;
  assign ld_take  = load & ld_ok;
  assign tc       = cnt_en & (up_dn ? cy[NDIG] : bw[NDIG]);
  // In saturate mode the end value freezes the count but still reports ovf.
  assign hold_end = (SAT != 0) & tc;
  assign step     = cnt_en & ~load & ~hold_end;

  assign cy[0] = 1'b1;
  assign bw[0] = 1'b1;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    assign dig_ok[g] = is_bcd(ld_d[g]);
    assign cy[g+1]   = cy[g] & is9[g];
    assign bw[g+1]   = bw[g] & is0[g];
    assign inc[g]    = step & up_dn & cy[g];
    assign dec[g]    = step & ~up_dn & bw[g];

    bcd_digit u_dig (
      .clk  (clk),
      .rstn (rstn),
      .sclr (sclr),
      .ld   (ld_take),
      .ld_d (ld_d[g]),
      .inc  (inc[g]),
      .dec  (dec[g]),
      .q    (q[g]),
      .is9  (is9[g]),
      .is0  (is0[g])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf    <= 1'b0;
      ld_err <= 1'b0;
    end else if (sclr) begin
      ovf    <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      ovf    <= ~load & tc;
      ld_err <= load & ~ld_ok;
    end
  end
endmodule
